aes_key_expander: RTL and testbench

Parametrised AES key-schedule engine supporting 128-, 192- and 256-bit cipher keys, selected per key load. It expands the cipher key one 32-bit word per cycle into an internal round-key store. The store holds up to 15 round keys and is read back as 128-bit round keys through a registered read port by the cipher datapath. It is the multi-key-length successor to the team's fixed AES-128 round-key generator.

---
 rtl/aes_key_expander.sv | 161 ++++++++++++++++
 tb/tb_aes_key_expander.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128/192/256 key schedule, one word per cycle, with a registered round-key read port
// Ports:
//   clk, n_rst                     clock, asynchronous active-low reset
//   i_start, i_key_mode, i_key_in  load a cipher key (MSB-aligned) and begin expansion
//   o_busy, o_done, o_num_rounds   expansion status and Nr of the loaded key
//   o_mode_err                     one-cycle pulse for a start with an unsupported mode
//   i_rd_en, i_rd_round            round-key read request
//   o_rd_data, o_rd_valid          registered round key, one cycle after the request
module aes_key_expander #(
  parameter int MAX_KEY_BITS = 256,
  parameter int SBOX_INST    = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_start,
  input  logic [1:0]   i_key_mode,
  input  logic [255:0] i_key_in,
  output logic         o_busy,
  output logic         o_done,
  output logic [3:0]   o_num_rounds,
  output logic         o_mode_err,
  input  logic         i_rd_en,
  input  logic [3:0]   i_rd_round,
  output logic [127:0] o_rd_data,
  output logic         o_rd_valid
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (product of b^2..b^128), then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t        r_state;
  logic          r_busy, r_done, r_mode_err, r_rd_valid;
  logic [3:0]    r_nk, r_nr;
  logic [5:0]    r_i;
  logic [2:0]    r_imod;
  logic [7:0]    r_rcon;
  logic [127:0]  r_rd_data;
  logic [31:0]   r_store [60];
  // r_win[7] = w[i-1], r_win[8-Nk] = w[i-Nk]
  logic [31:0]   r_win [8];

  logic [31:0]   w_kw [8];
  logic [31:0]   w_sub_in, w_sub, w_temp, w_old, w_new;
  logic [3:0]    w_nk, w_nr;
  logic [5:0]    w_rd_base;
  logic          w_mode_ok, w_accept, w_last, w_rd_ok;

  for (genvar k = 0; k < 8; k++) begin : g_kw
    assign w_kw[k] = i_key_in[255-32*k -: 32];
  end

  for (genvar g = 0; g < SBOX_INST; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = sbox(w_sub_in[8*g +: 8]);
  end

  assign w_mode_ok = (i_key_mode != 2'b11) && ((128 + 64 * int'(i_key_mode)) <= MAX_KEY_BITS);
  assign w_accept  = i_start && w_mode_ok && (r_state != EXPAND);
  assign w_nk      = 4'd4 + {1'b0, i_key_mode, 1'b0};
  assign w_nr      = w_nk + 4'd6;
  assign w_last    = r_i == ({r_nr, 2'b00} + 6'd3);
  assign w_sub_in  = (r_imod == 3'd0) ? {r_win[7][23:0], r_win[7][31:24]} : r_win[7];
  assign w_temp    = (r_imod == 3'd0) ? w_sub ^ {r_rcon, 24'h0} :
                     (r_nk == 4'd8 && r_imod == 3'd4) ? w_sub : r_win[7];
  assign w_old     = (r_nk == 4'd4) ? r_win[4] : (r_nk == 4'd6) ? r_win[2] : r_win[0];
  assign w_new     = w_old ^ w_temp;
  // A start accepted on this edge invalidates the keys being read
  assign w_rd_ok   = r_done && !w_accept && (i_rd_round <= r_nr);
  assign w_rd_base = {i_rd_round, 2'b00};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_nk       <= 4'd0;
      r_nr       <= 4'd0;
      r_i        <= 6'd0;
      r_imod     <= 3'd0;
      r_rcon     <= 8'h00;
      r_mode_err <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_mode_err <= i_start && !w_mode_ok;
      if (i_rd_en) begin
        r_rd_valid <= w_rd_ok;
        r_rd_data  <= w_rd_ok ? {r_store[w_rd_base], r_store[w_rd_base + 6'd1],
                                 r_store[w_rd_base + 6'd2], r_store[w_rd_base + 6'd3]} : '0;
      end else begin
        r_rd_valid <= 1'b0;
      end
      if (w_accept) begin
        r_state <= EXPAND;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_nk    <= w_nk;
        r_nr    <= w_nr;
        r_i     <= {2'b00, w_nk};
        r_imod  <= 3'd0;
        r_rcon  <= 8'h01;
      end else if (r_state == EXPAND) begin
        r_i    <= r_i + 6'd1;
        r_imod <= (r_imod == r_nk[2:0] - 3'd1) ? 3'd0 : r_imod + 3'd1;
        r_rcon <= (r_imod == 3'd0) ? xtime(r_rcon) : r_rcon;
        if (w_last) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  // Word store and window carry no reset; they are only exposed once done is set
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < 8; k++) begin
        r_win[k] <= w_kw[3'(k) + w_nk[2:0]];
        if (4'(k) < w_nk) r_store[k] <= w_kw[k];
      end
    end else if (r_state == EXPAND) begin
      for (int k = 0; k < 7; k++) r_win[k] <= r_win[k+1];
      r_win[7]     <= w_new;
      r_store[r_i] <= w_new;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_num_rounds = r_nr;
  assign o_mode_err   = r_mode_err;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: FIPS-197 directed vectors against a behavioural key-schedule model
module tb_aes_key_expander;
  logic         clk, n_rst, start, rd_en;
  logic [1:0]   key_mode;
  logic [255:0] key_in;
  logic [3:0]   rd_round;
  logic         o_busy, o_done, o_mode_err, o_rd_valid;
  logic [3:0]   o_num_rounds;
  logic [127:0] o_rd_data;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expander dut (
    .clk(clk), .n_rst(n_rst), .i_start(start), .i_key_mode(key_mode), .i_key_in(key_in),
    .o_busy(o_busy), .o_done(o_done), .o_num_rounds(o_num_rounds), .o_mode_err(o_mode_err),
    .i_rd_en(rd_en), .i_rd_round(rd_round), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  logic [7:0]  sb [256];
  logic [7:0]  rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] e_w [60];
  logic        e_busy, e_done, e_merr, e_rv, m_acc;
  logic [3:0]  e_nr;
  logic [127:0] e_rd;
  int          e_left;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box by brute-force inverse search and bitwise affine transform
  initial begin
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = s;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
    int nk, nw;
    logic [31:0] t;
    nk = 4 + 2 * int'(m);
    nw = 4 * (nk + 7);
    for (int j = 0; j < nk; j++) e_w[j] = k[255-32*j -: 32];
    for (int i = nk; i < nw; i++) begin
      t = e_w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      e_w[i] = e_w[i-nk] ^ t;
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      e_busy = 0; e_done = 0; e_nr = 0; e_merr = 0; e_rv = 0; e_rd = 0; e_left = 0;
    end else begin
      m_acc  = start && key_mode != 2'b11 && !e_busy;
      e_merr = start && key_mode == 2'b11;
      if (rd_en) begin
        e_rv = e_done && !m_acc && rd_round <= e_nr;
        e_rd = e_rv ? {e_w[4*rd_round], e_w[4*rd_round+1], e_w[4*rd_round+2], e_w[4*rd_round+3]} : '0;
      end else e_rv = 0;
      if (m_acc) begin
        model_expand(key_mode, key_in);
        e_nr   = 4'(10 + 2 * int'(key_mode));
        e_busy = 1;
        e_done = 0;
        e_left = 4 * (int'(e_nr) + 1) - (4 + 2 * int'(key_mode));
      end else if (e_busy) begin
        e_left--;
        if (e_left == 0) begin e_busy = 0; e_done = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if ({o_busy, o_done, o_num_rounds, o_mode_err} !== {e_busy, e_done, e_nr, e_merr}) begin
        n_err++;
        $display("FAIL ctl t=%0t got busy=%b done=%b nr=%0d merr=%b exp busy=%b done=%b nr=%0d merr=%b",
                 $time, o_busy, o_done, o_num_rounds, o_mode_err, e_busy, e_done, e_nr, e_merr);
      end
      n_chk++;
      if (o_rd_valid !== e_rv || o_rd_data !== e_rd) begin
        n_err++;
        $display("FAIL rd t=%0t got v=%b d=%h exp v=%b d=%h", $time, o_rd_valid, o_rd_data, e_rv, e_rd);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic go(input logic [1:0] m, input logic [255:0] k);
    start = 1; key_mode = m; key_in = k;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int exp_n, input string nm);
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 128'(n), 128'(exp_n));
  endtask

  task automatic rd(input logic [3:0] r, input logic [127:0] exp, input logic ev, input string nm);
    rd_en = 1; rd_round = r;
    @(negedge clk);
    rd_en = 0;
    chk({nm, "_v"}, 128'(o_rd_valid), 128'(ev));
    chk(nm, o_rd_data, exp);
  endtask

  initial begin
    clk = 0; n_rst = 1; start = 0; rd_en = 0; key_mode = 0; key_in = 0; rd_round = 0;
    #1 n_rst = 0;
    chk_on = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(o_busy), 0);
    chk("rst_done", 128'(o_done), 0);
    chk("rst_nr", 128'(o_num_rounds), 0);
    chk("rst_rv", 128'(o_rd_valid), 0);
    chk("rst_rd", o_rd_data, 0);
    chk("sbox_00", 128'(sb[0]), 128'h63);
    chk("sbox_01", 128'(sb[1]), 128'h7c);
    chk("sbox_53", 128'(sb[8'h53]), 128'hed);
    n_rst = 1;
    @(negedge clk);
    go(2'b00, K128);
    chk("busy128", 128'(o_busy), 1);
    wait_done(40, "lat128");
    chk("nr128", 128'(o_num_rounds), 10);
    rd(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1, "r128_0");
    rd(1, 128'ha0fafe1788542cb123a339392a6c7605, 1, "r128_1");
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, "r128_10");
    rd(11, 128'h0, 0, "r128_11");
    start = 1; key_mode = 2'b11;
    @(negedge clk);
    start = 0;
    chk("merr", 128'(o_mode_err), 1);
    chk("merr_done", 128'(o_done), 1);
    chk("merr_nr", 128'(o_num_rounds), 10);
    @(negedge clk);
    chk("merr_pulse", 128'(o_mode_err), 0);
    go(2'b01, K192);
    wait_done(46, "lat192");
    chk("nr192", 128'(o_num_rounds), 12);
    rd(0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1, "r192_0");
    rd(12, 128'he98ba06f448c773c8ecc720401002202, 1, "r192_12");
    start = 1; key_mode = 2'b10; key_in = K256; rd_en = 1; rd_round = 0;
    @(negedge clk);
    start = 0;
    chk("simul_rv", 128'(o_rd_valid), 0);
    chk("restart_done", 128'(o_done), 0);
    repeat (3) @(negedge clk);
    chk("expand_rv", 128'(o_rd_valid), 0);
    rd_en = 0;
    wait_done(52 - 3, "lat256");
    chk("nr256", 128'(o_num_rounds), 14);
    rd(0, 128'h603deb1015ca71be2b73aef0857d7781, 1, "r256_0");
    rd(14, 128'hfe4890d1e6188d0b046df344706c631e, 1, "r256_14");
    go(2'b00, K128);
    repeat (10) @(negedge clk);
    go(2'b10, K256);
    wait_done(40 - 11, "lat_ignore");
    chk("nr_ignore", 128'(o_num_rounds), 10);
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, "r_ignore_10");
    go(2'b00, K128);
    repeat (20) @(negedge clk);
    #2 n_rst = 0;
    #1;
    chk("arst_busy", 128'(o_busy), 0);
    chk("arst_done", 128'(o_done), 0);
    chk("arst_nr", 128'(o_num_rounds), 0);
    chk("arst_rv", 128'(o_rd_valid), 0);
    chk("arst_rd", o_rd_data, 0);
    @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    go(2'b01, K192);
    wait_done(46, "lat_post_rst");
    rd(12, 128'he98ba06f448c773c8ecc720401002202, 1, "r_post_rst_12");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
